// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache miss refill engine
// Detects a fetch miss, requests one aligned line, gathers beats and pulses the line write.
module icache_refill #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int BUS_WIDTH   = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_icache_hit,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    output logic                   o_stall_fetch,
    output logic                   o_instr_we,
    output logic [BLOCK_WIDTH-1:0] o_instr_block,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_data_valid,
    input  logic [BUS_WIDTH-1:0]   i_mem_data
);
    localparam int BEATS = BLOCK_WIDTH / BUS_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS  = $clog2(BLOCK_WIDTH / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

    state_t        state;
    logic [CW-1:0] beat;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state           <= IDLE;
            beat            <= '0;
            o_mem_req_valid <= 1'b0;
            o_instr_we      <= 1'b0;
            o_mem_addr      <= '0;
            o_instr_block   <= '0;
        end else begin
            o_instr_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (!i_icache_hit) begin
                        o_mem_addr      <= {i_pc[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
                        o_mem_req_valid <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        beat            <= '0;
                        state           <= FILL;
                    end
                end
                FILL: begin
                    // Beat 0 is the lowest address, so it lands in the least significant slice
                    if (i_mem_data_valid) begin
                        o_instr_block[beat*BUS_WIDTH +: BUS_WIDTH] <= i_mem_data;
                        beat <= beat + 1'b1;
                        if (beat == LAST) begin
                            o_instr_we <= 1'b1;
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational so the PC is frozen in the very cycle the miss is seen
    assign o_stall_fetch = (state != IDLE) || !i_icache_hit;

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - scoreboard bench for icache_refill
// Stimulus pushes expected line writes; a negedge monitor pops and compares each o_instr_we pulse.
module tb_icache_refill;
    logic         i_clk = 1'b0;
    logic         i_arst;
    logic         i_icache_hit;
    logic [63:0]  i_pc;
    logic         o_stall_fetch;
    logic         o_instr_we;
    logic [511:0] o_instr_block;
    logic         o_mem_req_valid;
    logic         i_mem_req_ready;
    logic [63:0]  o_mem_addr;
    logic         i_mem_data_valid;
    logic [63:0]  i_mem_data;

    icache_refill dut (
        .i_clk            (i_clk),
        .i_arst           (i_arst),
        .i_icache_hit     (i_icache_hit),
        .i_pc             (i_pc),
        .o_stall_fetch    (o_stall_fetch),
        .o_instr_we       (o_instr_we),
        .o_instr_block    (o_instr_block),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_addr       (o_mem_addr),
        .i_mem_data_valid (i_mem_data_valid),
        .i_mem_data       (i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [511:0] blk;
        logic [63:0]  addr;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [511:0] last_blk = '0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        if (o_instr_we === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("we_cycle", cyc, e.cyc);
                check("we_block", o_instr_block, e.blk);
                check("we_addr", o_mem_addr, e.addr);
            end
        end
    end

    // One complete miss: r cycles of ready low, gap bit b inserts an idle cycle before beat b
    task automatic do_miss(input logic [63:0] pc, input int r, input logic [7:0] gaps,
                           input logic [63:0] base, input logic [63:0] stride, input logic junk);
        logic [511:0] blk;
        logic [63:0]  addr;
        int           g;
        exp_t         e;
        g = 0;
        for (int b = 0; b < 8; b++) begin
            blk[b*64 +: 64] = base + 64'(b) * stride;
            g += int'(gaps[b]);
        end
        addr = {pc[63:6], 6'b0};
        i_icache_hit     = 1'b0;
        i_pc             = pc;
        i_mem_req_ready  = 1'b0;
        i_mem_data_valid = junk;
        i_mem_data       = 64'hBAD0_BAD0_BAD0_BAD0;
        e.blk = blk;
        e.addr = addr;
        e.cyc = cyc + 10 + r + g;
        sb.push_back(e);
        @(negedge i_clk);
        check("stall_miss_cycle", o_stall_fetch, 1'b1);
        check("req_not_yet", o_mem_req_valid, 1'b0);
        tick;
        for (int i = 0; i < r; i++) begin
            @(negedge i_clk);
            check("req_wait_valid", o_mem_req_valid, 1'b1);
            check("req_wait_addr", o_mem_addr, addr);
            tick;
        end
        i_mem_req_ready = 1'b1;
        @(negedge i_clk);
        check("req_valid", o_mem_req_valid, 1'b1);
        check("req_addr", o_mem_addr, addr);
        tick;
        i_mem_req_ready  = 1'b0;
        i_mem_data_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (gaps[b]) begin
                i_mem_data_valid = 1'b0;
                @(negedge i_clk);
                check("stall_gap", o_stall_fetch, 1'b1);
                tick;
            end
            i_mem_data_valid = 1'b1;
            i_mem_data       = base + 64'(b) * stride;
            tick;
        end
        i_mem_data_valid = 1'b0;
        i_icache_hit     = 1'b1;
        @(negedge i_clk);
        check("stall_write", o_stall_fetch, 1'b1);
        tick;
        @(negedge i_clk);
        check("stall_release", o_stall_fetch, 1'b0);
        check("we_after_write", o_instr_we, 1'b0);
        last_blk = blk;
        tick;
    endtask

    initial begin
        i_arst = 1'b1;
        i_icache_hit = 1'b1;
        i_pc = '0;
        i_mem_req_ready = 1'b0;
        i_mem_data_valid = 1'b0;
        i_mem_data = '0;
        #1;
        check("rst_stall_hit", o_stall_fetch, 1'b0);
        check("rst_we", o_instr_we, 1'b0);
        check("rst_req", o_mem_req_valid, 1'b0);
        check("rst_addr", o_mem_addr, 64'h0);
        check("rst_block", o_instr_block, 512'h0);
        i_icache_hit = 1'b0;
        #1;
        check("rst_stall_miss", o_stall_fetch, 1'b1);
        i_icache_hit = 1'b1;
        tick;
        tick;
        i_arst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            check("hit_stall", o_stall_fetch, 1'b0);
            check("hit_req", o_mem_req_valid, 1'b0);
            check("hit_we", o_instr_we, 1'b0);
            tick;
        end

        do_miss(64'h1234, 0, 8'b0000_0000, 64'h0, 64'h1, 1'b0);
        check("basic_lo", o_instr_block[63:0], 512'h0);
        check("basic_hi", o_instr_block[511:448], 512'h7);

        do_miss(64'h1234, 5, 8'b0000_0000, 64'hA000_0000_0000_00A0, 64'h1111_1111_1111_1111, 1'b0);

        do_miss(64'h8000_0000_0000_ABCD, 0, 8'b0010_1010, 64'h5555_0000_0000_0001, 64'h0001_0001_0001_0001, 1'b0);

        i_mem_data_valid = 1'b1;
        i_mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("idle_data_block", o_instr_block, last_blk);
            check("idle_data_we", o_instr_we, 1'b0);
            tick;
        end
        do_miss(64'h0000_0000_0003_0047, 2, 8'b0000_0000, 64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);

        i_icache_hit = 1'b0;
        i_pc = 64'h4440;
        tick;
        i_mem_req_ready = 1'b1;
        tick;
        i_mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            i_mem_data_valid = 1'b1;
            i_mem_data = 64'hEEEE_0000_0000_0000 + 64'(b);
            tick;
        end
        i_mem_data_valid = 1'b0;
        #1;
        i_arst = 1'b1;
        #1;
        check("arst_req", o_mem_req_valid, 1'b0);
        check("arst_we", o_instr_we, 1'b0);
        check("arst_addr", o_mem_addr, 64'h0);
        check("arst_block", o_instr_block, 512'h0);
        check("arst_stall_miss", o_stall_fetch, 1'b1);
        i_icache_hit = 1'b1;
        #1;
        check("arst_stall_hit", o_stall_fetch, 1'b0);
        tick;
        tick;
        i_arst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            check("post_arst_idle_we", o_instr_we, 1'b0);
            tick;
        end

        do_miss(64'hDEAD_BEEF_0000_1FFF, 0, 8'b0000_0000, 64'hC0DE_0000_0000_0000, 64'h0000_0001_0000_0001, 1'b0);

        repeat (5) tick;
        check("sb_drained", 512'(sb.size()), 512'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
